// File: rtl/cache_dma_axi_rx.sv
`default_nettype none
// ============================================================================
// Module      : cache_dma_axi_rx
// Description : Read path from arbitrated cache DMA requests to one AXI4
//               master read port. One AR burst per request; the requesting
//               cache id is held in an in-order tag FIFO and each returned
//               R beat is split into cache-width words steered to that cache.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_dma_axi_rx #(
    parameter int num_cache_p           = 4,
    parameter int addr_width_p          = 32,
    parameter int data_width_p          = 32,
    parameter int block_size_in_words_p = 8,
    parameter int tag_fifo_els_p        = num_cache_p,
    parameter int axi_id_width_p        = 6,
    parameter int axi_data_width_p      = 64,
    parameter int axi_burst_len_p       = 4,
    parameter int axi_burst_type_p      = 1,
    localparam int lg_num_cache_lp      = (num_cache_p > 1) ? $clog2(num_cache_p) : 1
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,

    input  logic                                      v_i,
    output logic                                      yumi_o,
    input  logic [lg_num_cache_lp-1:0]                cache_id_i,
    input  logic [addr_width_p-1:0]                   addr_i,

    output logic [num_cache_p-1:0][data_width_p-1:0]  dma_data_o,
    output logic [num_cache_p-1:0]                    dma_data_v_o,
    input  logic [num_cache_p-1:0]                    dma_data_ready_i,

    output logic [axi_id_width_p-1:0]                 axi_arid_o,
    output logic [addr_width_p-1:0]                   axi_araddr_addr_o,
    output logic [lg_num_cache_lp-1:0]                axi_araddr_cache_id_o,
    output logic [7:0]                                axi_arlen_o,
    output logic [2:0]                                axi_arsize_o,
    output logic [1:0]                                axi_arburst_o,
    output logic [3:0]                                axi_arcache_o,
    output logic [2:0]                                axi_arprot_o,
    output logic                                      axi_arlock_o,
    output logic                                      axi_arvalid_o,
    input  logic                                      axi_arready_i,

    input  logic [axi_id_width_p-1:0]                 axi_rid_i,
    input  logic [axi_data_width_p-1:0]               axi_rdata_i,
    input  logic [1:0]                                axi_rresp_i,
    input  logic                                      axi_rlast_i,
    input  logic                                      axi_rvalid_i,
    output logic                                      axi_rready_o
);

    localparam int c_ratio    = axi_data_width_p / data_width_p;
    localparam int c_lg_ratio = (c_ratio > 1) ? $clog2(c_ratio) : 1;
    localparam int c_lg_beats = (axi_burst_len_p > 1) ? $clog2(axi_burst_len_p) : 1;
    localparam int c_lg_els   = (tag_fifo_els_p > 1) ? $clog2(tag_fifo_els_p) : 1;
    localparam int c_lg_cnt   = $clog2(tag_fifo_els_p + 1);

    localparam logic [c_lg_ratio-1:0] c_word_last = c_lg_ratio'(c_ratio - 1);
    localparam logic [c_lg_beats-1:0] c_beat_last = c_lg_beats'(axi_burst_len_p - 1);
    localparam logic [c_lg_els-1:0]   c_ptr_last  = c_lg_els'(tag_fifo_els_p - 1);
    localparam logic [c_lg_cnt-1:0]   c_cnt_full  = c_lg_cnt'(tag_fifo_els_p);

    // A block must be exactly one burst of AXI beats
    if (data_width_p * block_size_in_words_p != axi_data_width_p * axi_burst_len_p) begin : g_bad_geometry
        $error("cache_dma_axi_rx: block size does not match one AXI burst");
    end

    logic [lg_num_cache_lp-1:0] r_tags [tag_fifo_els_p];
    logic [c_lg_els-1:0]        r_wr_ptr;
    logic [c_lg_els-1:0]        r_rd_ptr;
    logic [c_lg_cnt-1:0]        r_count;
    logic [c_lg_ratio-1:0]      r_word_cnt;
    logic [c_lg_beats-1:0]      r_beat_cnt;

    logic                       w_empty;
    logic                       w_full;
    logic                       w_push;
    logic                       w_pop;
    logic [lg_num_cache_lp-1:0] w_head;
    logic                       w_word_v;
    logic                       w_word_hs;
    logic                       w_last_word;
    logic                       w_last_beat;
    logic [data_width_p-1:0]    w_words [c_ratio];
    logic [data_width_p-1:0]    w_word;
    logic                       w_unused_ok;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_cnt_full);
    assign w_head  = r_tags[r_rd_ptr];

    // AR channel: combinational, gated by reset so nothing leaks out while held
    assign axi_arvalid_o         = reset_i & v_i & ~w_full;
    assign yumi_o                = axi_arvalid_o & axi_arready_i;
    assign w_push                = yumi_o;
    assign axi_arid_o            = '0;
    assign axi_araddr_addr_o     = addr_i;
    assign axi_araddr_cache_id_o = cache_id_i;
    assign axi_arlen_o           = 8'(axi_burst_len_p - 1);
    assign axi_arsize_o          = 3'($clog2(axi_data_width_p / 8));
    assign axi_arburst_o         = 2'(axi_burst_type_p);
    assign axi_arcache_o         = 4'b0000;
    assign axi_arprot_o          = 3'b000;
    assign axi_arlock_o          = 1'b0;

    // Beat is sliced lowest word first
    for (genvar g = 0; g < c_ratio; g++) begin : g_word_slice
        assign w_words[g] = axi_rdata_i[g*data_width_p +: data_width_p];
    end
    assign w_word = w_words[r_word_cnt];

    for (genvar g = 0; g < num_cache_p; g++) begin : g_lane
        assign dma_data_o[g] = w_word;
    end

    // R channel: the head tag owns the data; the beat is acked with its last word
    assign w_word_v     = reset_i & axi_rvalid_i & ~w_empty;
    assign dma_data_v_o = w_word_v ? (num_cache_p'(1) << w_head) : '0;
    assign w_word_hs    = w_word_v & dma_data_ready_i[w_head];
    assign w_last_word  = (r_word_cnt == c_word_last);
    assign w_last_beat  = (r_beat_cnt == c_beat_last);
    assign axi_rready_o = w_word_hs & w_last_word;
    assign w_pop        = axi_rready_o & w_last_beat;

    assign w_unused_ok  = &{1'b0, axi_rid_i, axi_rresp_i, axi_rlast_i};

    // Tag storage: written on AR acceptance, contents need no reset
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_tags[r_wr_ptr] <= cache_id_i;
        end
    end

    // FIFO pointers/occupancy and word/beat counters; reset drops everything in flight
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_word_cnt <= '0;
            r_beat_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_word_hs) begin
                r_word_cnt <= w_last_word ? '0 : r_word_cnt + 1'b1;
            end
            if (axi_rready_o) begin
                r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_dma_axi_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_dma_axi_rx
// Description : Scoreboard bench for cache_dma_axi_rx. Stimulus pushes the
//               expected AR fields and fill words into queues; a monitor
//               pops and compares on every AR and word handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_dma_axi_rx;

    typedef struct packed {
        logic [1:0]  cache;
        logic [31:0] data;
    } exp_t;

    logic              clk_i;
    logic              reset_i;
    logic              v_i;
    logic              yumi_o;
    logic [1:0]        cache_id_i;
    logic [31:0]       addr_i;
    logic [3:0][31:0]  dma_data_o;
    logic [3:0]        dma_data_v_o;
    logic [3:0]        dma_data_ready_i;
    logic [5:0]        axi_arid_o;
    logic [31:0]       axi_araddr_addr_o;
    logic [1:0]        axi_araddr_cache_id_o;
    logic [7:0]        axi_arlen_o;
    logic [2:0]        axi_arsize_o;
    logic [1:0]        axi_arburst_o;
    logic [3:0]        axi_arcache_o;
    logic [2:0]        axi_arprot_o;
    logic              axi_arlock_o;
    logic              axi_arvalid_o;
    logic              axi_arready_i;
    logic [5:0]        axi_rid_i;
    logic [63:0]       axi_rdata_i;
    logic [1:0]        axi_rresp_i;
    logic              axi_rlast_i;
    logic              axi_rvalid_i;
    logic              axi_rready_o;

    cache_dma_axi_rx dut (
        .clk_i                 (clk_i),
        .reset_i               (reset_i),
        .v_i                   (v_i),
        .yumi_o                (yumi_o),
        .cache_id_i            (cache_id_i),
        .addr_i                (addr_i),
        .dma_data_o            (dma_data_o),
        .dma_data_v_o          (dma_data_v_o),
        .dma_data_ready_i      (dma_data_ready_i),
        .axi_arid_o            (axi_arid_o),
        .axi_araddr_addr_o     (axi_araddr_addr_o),
        .axi_araddr_cache_id_o (axi_araddr_cache_id_o),
        .axi_arlen_o           (axi_arlen_o),
        .axi_arsize_o          (axi_arsize_o),
        .axi_arburst_o         (axi_arburst_o),
        .axi_arcache_o         (axi_arcache_o),
        .axi_arprot_o          (axi_arprot_o),
        .axi_arlock_o          (axi_arlock_o),
        .axi_arvalid_o         (axi_arvalid_o),
        .axi_arready_i         (axi_arready_i),
        .axi_rid_i             (axi_rid_i),
        .axi_rdata_i           (axi_rdata_i),
        .axi_rresp_i           (axi_rresp_i),
        .axi_rlast_i           (axi_rlast_i),
        .axi_rvalid_i          (axi_rvalid_i),
        .axi_rready_o          (axi_rready_o)
    );

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          hs_total = 0;
    int          first_hs = -1;
    int          last_hs = -1;
    bit          wpar = 1'b0;
    bit          rv_hs = 1'b0;
    logic [63:0] beat_q [$];
    exp_t        exp_q [$];
    exp_t        ar_q [$];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // One block as 4 beats; each beat carries {base+2k+1, base+2k}
    task automatic push_burst(input logic [1:0] cache, input logic [31:0] base);
        for (int b = 0; b < 4; b++) begin
            logic [31:0] w0;
            logic [31:0] w1;
            w0 = base + 32'(2*b);
            w1 = base + 32'(2*b + 1);
            beat_q.push_back({w1, w0});
            exp_q.push_back('{cache: cache, data: w0});
            exp_q.push_back('{cache: cache, data: w1});
        end
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        forever begin
            @(negedge clk_i); #1;
            if (yumi_o) break;
            n++;
            if (n > 200) begin
                timeout_fail("ar_accept");
                break;
            end
        end
        @(posedge clk_i); #1;
        v_i = 1'b0;
    endtask

    task automatic send_req(input logic [1:0] cache, input logic [31:0] addr);
        v_i        = 1'b1;
        cache_id_i = cache;
        addr_i     = addr;
        ar_q.push_back('{cache: cache, data: addr});
        wait_accept();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((beat_q.size() != 0 || exp_q.size() != 0) && n < 400) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (n >= 400) begin
            timeout_fail("drain");
            beat_q.delete();
            exp_q.delete();
        end
        check("ar_queue_empty", 64'(ar_q.size()), 64'd0);
    endtask

    // R-channel responder: presents queued beats back to back
    initial begin
        axi_rvalid_i = 1'b0;
        axi_rdata_i  = '0;
        axi_rid_i    = '0;
        axi_rresp_i  = '0;
        axi_rlast_i  = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            if (rv_hs && beat_q.size() != 0) begin
                logic [63:0] d;
                d = beat_q.pop_front();
            end
            if (beat_q.size() != 0) begin
                axi_rvalid_i = 1'b1;
                axi_rdata_i  = beat_q[0];
            end else begin
                axi_rvalid_i = 1'b0;
                axi_rdata_i  = '0;
            end
        end
    end

    // Monitor: compares AR handshakes and fill words against the scoreboard
    initial begin
        forever begin
            bit   w_hs;
            exp_t e;
            @(negedge clk_i); #2;
            if (axi_arvalid_o && axi_arready_i) begin
                if (ar_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL ar_unexpected: got addr 0x%0h expected none", axi_araddr_addr_o);
                end else begin
                    e = ar_q.pop_front();
                    check("ar_addr", 64'(axi_araddr_addr_o), 64'(e.data));
                    check("ar_cache_id", 64'(axi_araddr_cache_id_o), 64'(e.cache));
                    check("ar_const", {axi_arid_o, axi_arlen_o, axi_arsize_o, axi_arburst_o,
                                       axi_arcache_o, axi_arprot_o, axi_arlock_o},
                          {6'd0, 8'd3, 3'd3, 2'd1, 4'd0, 3'd0, 1'b0});
                end
            end
            rv_hs = axi_rvalid_i && axi_rready_o;
            w_hs  = 1'b0;
            for (int c = 0; c < 4; c++) begin
                if (dma_data_v_o[c] && dma_data_ready_i[c]) begin
                    w_hs = 1'b1;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL word_unexpected: got 0x%0h on cache %0d expected none", dma_data_o[c], c);
                    end else begin
                        e = exp_q.pop_front();
                        check("word_cache", 64'(c), 64'(e.cache));
                        check("word_data", 64'(dma_data_o[c]), 64'(e.data));
                    end
                end
            end
            if (axi_rvalid_i) begin
                check("rready", 64'(axi_rready_o), 64'(w_hs && wpar));
                check("v_onehot", 64'($countones(dma_data_v_o) <= 1), 64'd1);
            end
            if (w_hs) begin
                wpar = ~wpar;
                hs_total++;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
            if (!reset_i) wpar = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int h0;
        reset_i          = 1'b0;
        v_i              = 1'b1;
        cache_id_i       = 2'd2;
        addr_i           = 32'hDEAD_0000;
        dma_data_ready_i = 4'hF;
        axi_arready_i    = 1'b1;
        beat_q.push_back(64'h1234_5678_9ABC_DEF0);

        // Reset: request and data present, but every handshake output held low
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_arvalid", 64'(axi_arvalid_o), 64'd0);
        check("rst_yumi", 64'(yumi_o), 64'd0);
        check("rst_rready", 64'(axi_rready_o), 64'd0);
        check("rst_dma_v", 64'(dma_data_v_o), 64'd0);
        beat_q.delete();
        v_i = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b1;
        @(posedge clk_i); #1;

        // Single read, cache 2, addr 0x1000: 8 words in 8 cycles
        first_hs   = -1;
        h0         = hs_total;
        v_i        = 1'b1;
        cache_id_i = 2'd2;
        addr_i     = 32'h0000_1000;
        ar_q.push_back('{cache: 2'd2, data: 32'h0000_1000});
        #1;
        check("single_arvalid_same_cycle", 64'(axi_arvalid_o), 64'd1);
        wait_accept();
        push_burst(2'd2, 32'd0);
        wait_drain();
        check("single_word_count", 64'(hs_total - h0), 64'd8);
        check("single_span", 64'(last_hs - first_hs), 64'd7);

        // Backpressure on cache 2
        send_req(2'd2, 32'h0000_2040);
        push_burst(2'd2, 32'h0000_0100);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk_i); #1;
            dma_data_ready_i[2] = ~dma_data_ready_i[2];
            n++;
        end
        dma_data_ready_i = 4'hF;
        wait_drain();

        // Four outstanding requests, fifth stalls on a full tag FIFO
        for (int i = 0; i < 4; i++) begin
            send_req(2'(i), 32'h0000_4000 + 32'(i * 32));
        end
        v_i        = 1'b1;
        cache_id_i = 2'd0;
        addr_i     = 32'h0000_5000;
        ar_q.push_back('{cache: 2'd0, data: 32'h0000_5000});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i); #1;
            check("full_arvalid", 64'(axi_arvalid_o), 64'd0);
            check("full_yumi", 64'(yumi_o), 64'd0);
        end
        push_burst(2'd0, 32'hA000_0000);
        push_burst(2'd1, 32'hA100_0000);
        push_burst(2'd2, 32'hA200_0000);
        push_burst(2'd3, 32'hA300_0000);
        wait_accept();
        push_burst(2'd0, 32'hA400_0000);
        wait_drain();

        // AR stall for 5 cycles
        axi_arready_i = 1'b0;
        v_i           = 1'b1;
        cache_id_i    = 2'd3;
        addr_i        = 32'h0000_6000;
        ar_q.push_back('{cache: 2'd3, data: 32'h0000_6000});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i); #1;
            check("stall_yumi", 64'(yumi_o), 64'd0);
            check("stall_arvalid", 64'(axi_arvalid_o), 64'd1);
            check("stall_araddr", 64'(axi_araddr_addr_o), 64'h6000);
        end
        @(posedge clk_i); #1;
        axi_arready_i = 1'b1;
        wait_accept();
        push_burst(2'd3, 32'hB000_0000);
        wait_drain();

        // Overlap: cache 1 AR accepted during the last beat of the cache 0 burst
        first_hs = -1;
        h0       = hs_total;
        send_req(2'd0, 32'h0000_7000);
        push_burst(2'd0, 32'hC000_0000);
        push_burst(2'd1, 32'hC100_0000);
        n = 0;
        begin
            int beats;
            beats = 0;
            while (n < 100) begin
                @(negedge clk_i); #1;
                n++;
                if (axi_rready_o) beats++;
                if (beats == 4) break;
            end
            if (beats != 4) timeout_fail("overlap_last_beat");
        end
        v_i        = 1'b1;
        cache_id_i = 2'd1;
        addr_i     = 32'h0000_7100;
        ar_q.push_back('{cache: 2'd1, data: 32'h0000_7100});
        #1;
        check("overlap_yumi", 64'(yumi_o), 64'd1);
        @(posedge clk_i); #1;
        v_i = 1'b0;
        wait_drain();
        check("overlap_word_count", 64'(hs_total - h0), 64'd16);
        check("overlap_span", 64'(last_hs - first_hs), 64'd15);

        // Asynchronous reset mid-burst, then a clean read
        h0 = hs_total;
        send_req(2'd3, 32'h0000_8000);
        push_burst(2'd3, 32'hD000_0000);
        n = 0;
        while (hs_total < h0 + 3 && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (n >= 100) timeout_fail("reset_midburst_words");
        @(posedge clk_i); #3;
        reset_i    = 1'b0;
        v_i        = 1'b1;
        cache_id_i = 2'd1;
        addr_i     = 32'h0000_9000;
        #1;
        check("async_rst_arvalid", 64'(axi_arvalid_o), 64'd0);
        check("async_rst_yumi", 64'(yumi_o), 64'd0);
        check("async_rst_rready", 64'(axi_rready_o), 64'd0);
        check("async_rst_dma_v", 64'(dma_data_v_o), 64'd0);
        beat_q.delete();
        exp_q.delete();
        ar_q.delete();
        v_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        h0 = hs_total;
        send_req(2'd1, 32'h0000_3000);
        push_burst(2'd1, 32'hE000_0000);
        wait_drain();
        check("post_reset_word_count", 64'(hs_total - h0), 64'd8);

        repeat (3) @(posedge clk_i);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
